// File: rtl/pwm_pkg.sv
// Shared constants and channel-mode helpers for the 16-channel PWM output block.
// Imported by both the timebase and the output mux.
package pwm_pkg;

    localparam logic [7:0] PWM_PERIOD_MAX  = 8'd254;
    localparam logic [7:0] DUTY_FULL       = 8'hFF;
    localparam int         DEFAULT_CLK_DIV = 13;
    localparam int         NUM_CH          = 16;

    typedef enum logic [1:0] {
        OFF,
        STATIC_HIGH,
        PWM
    } ch_mode_e;

    // Output enable dominates: a PWM-selected channel without its output enable stays off.
    function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
        if (!en_out) begin
            return OFF;
        end
        return en_pwm ? PWM : STATIC_HIGH;
    endfunction

endpackage

// File: rtl/pwm_peripheral_timebase.sv
// Shared PWM timebase: prescaler, 255-step period counter, double-buffered duty
// and the period_start pulse. Produces the common pwm_level for every channel.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] duty_in,
    output logic       pwm_level,
    output logic       period_start
);

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       duty_shadow_q, duty_shadow_d;
    logic             period_start_q, period_start_d;
    logic             tick;
    logic             wrap;

    assign tick = (div_cnt_q == DIV_LAST);
    assign wrap = tick && (pwm_cnt_q == PWM_PERIOD_MAX);

    always_comb begin
        div_cnt_d      = tick ? '0 : div_cnt_q + 1'b1;
        pwm_cnt_d      = pwm_cnt_q;
        duty_shadow_d  = duty_shadow_q;
        period_start_d = wrap;
        if (tick) begin
            pwm_cnt_d = wrap ? 8'd0 : pwm_cnt_q + 8'd1;
        end
        // Duty is only adopted at the period boundary so a period is never cut short.
        if (wrap) begin
            duty_shadow_d = duty_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            duty_shadow_q  <= '0;
            period_start_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_shadow_q  <= duty_shadow_d;
            period_start_q <= period_start_d;
        end
    end

    // Full-scale duty must never dip low, even at the last counter value.
    assign pwm_level    = (duty_shadow_q == DUTY_FULL) || (pwm_cnt_q < duty_shadow_q);
    assign period_start = period_start_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel output stage: per-channel off / static-high / PWM select driven from
// the SPI control registers, registered so no input reaches out combinationally.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [NUM_CH-1:0] out_q, out_d;
    logic              pwm_level;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .duty_in      (pwm_duty_cycle),
        .pwm_level    (pwm_level),
        .period_start (period_start)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ch_mode_e mode;
            logic     ch_d;

            assign mode = ch_mode(en_out[gi], en_pwm[gi]);

            always_comb begin
                ch_d = 1'b0;
                case (mode)
                    OFF:         ch_d = 1'b0;
                    STATIC_HIGH: ch_d = 1'b1;
                    PWM:         ch_d = pwm_level;
                    default:     ch_d = 1'b0;
                endcase
            end

            assign out_d[gi] = ch_d;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: a CLK_DIV=2 instance and a CLK_DIV=1 instance, a cycle
// scoreboard of expected outputs plus per-period high-time measurements.
module tb_pwm_peripheral;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1;
    logic        rst1 = 1'b1;
    logic [15:0] en_out = 16'h0000;
    logic [15:0] en_pwm = 16'h0000;
    logic [7:0]  duty = 8'd0;
    logic [15:0] out0, out1;
    logic        ps0, ps1;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(2)) dut0 (
        .clk             (clk),
        .rst             (rst0),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out0),
        .period_start    (ps0)
    );

    pwm_peripheral #(.CLK_DIV(1)) dut1 (
        .clk             (clk),
        .rst             (rst1),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out1),
        .period_start    (ps1)
    );

    typedef struct {
        logic [15:0] out0;
        logic        ps0;
        logic [15:0] out1;
        logic        ps1;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state per instance (index 0: CLK_DIV=2, index 1: CLK_DIV=1)
    int m_div[2] = '{0, 0};
    int m_cnt[2] = '{0, 0};
    int m_sh[2]  = '{0, 0};

    // Period measurement: cycles and high cycles since the previous period_start
    int cyc[2]      = '{0, 0};
    int hi[2]       = '{0, 0};
    int last_len[2] = '{0, 0};
    int last_hi[2]  = '{0, 0};
    logic ps_flag[2];
    int mon_bit = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic model_edge();
        exp_t        e;
        logic [15:0] eo[2];
        logic        ep[2];
        logic        r, tick, wrap, lvl;
        for (int d = 0; d < 2; d++) begin
            r    = (d == 0) ? rst0 : rst1;
            tick = (m_div[d] == div_of(d) - 1);
            wrap = tick && (m_cnt[d] == 254);
            lvl  = (m_sh[d] == 255) || (m_cnt[d] < m_sh[d]);
            for (int i = 0; i < 16; i++) begin
                eo[d][i] = r ? 1'b0 : (en_out[i] ? (en_pwm[i] ? lvl : 1'b1) : 1'b0);
            end
            ep[d] = r ? 1'b0 : wrap;
            if (r) begin
                m_div[d] = 0;
                m_cnt[d] = 0;
                m_sh[d]  = 0;
            end else begin
                if (wrap) m_sh[d] = int'(duty);
                m_div[d] = tick ? 0 : m_div[d] + 1;
                if (tick) m_cnt[d] = wrap ? 0 : m_cnt[d] + 1;
            end
        end
        e.out0 = eo[0];
        e.ps0  = ep[0];
        e.out1 = eo[1];
        e.ps1  = ep[1];
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t        e;
        logic [15:0] o;
        logic        p;
        int          b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("out0", {16'd0, out0}, {16'd0, e.out0});
            chk("ps0", {31'd0, ps0}, {31'd0, e.ps0});
            chk("out1", {16'd0, out1}, {16'd0, e.out1});
            chk("ps1", {31'd0, ps1}, {31'd0, e.ps1});
        end
        for (int d = 0; d < 2; d++) begin
            o = (d == 0) ? out0 : out1;
            p = (d == 0) ? ps0 : ps1;
            b = (d == 0) ? mon_bit : 0;
            cyc[d]++;
            if (o[b]) hi[d]++;
            ps_flag[d] = p;
            if (p) begin
                last_len[d] = cyc[d];
                last_hi[d]  = hi[d];
                cyc[d] = 0;
                hi[d]  = 0;
            end
        end
    endtask

    task automatic wait_ps(input int d);
        int got = 0;
        for (int k = 0; k < 2000; k++) begin
            step();
            if (ps_flag[d]) begin
                got = 1;
                break;
            end
        end
        if (got == 0) chk("ps_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_meas(input int d);
        cyc[d] = 0;
        hi[d]  = 0;
    endtask

    initial begin
        ps_flag[0] = 1'b0;
        ps_flag[1] = 1'b0;

        // Reset with static enables applied
        en_out = 16'h00FF;
        en_pwm = 16'h0000;
        repeat (3) begin
            step();
            chk("rst_out", {16'd0, out0}, 32'd0);
        end
        rst0 = 1'b0;
        rst1 = 1'b0;
        clear_meas(0);
        clear_meas(1);
        step();
        chk("static_out", {16'd0, out0}, 32'h0000_00FF);
        wait_ps(0);
        wait_ps(0);
        chk("static_period", last_len[0], 510);

        // 50% duty; the first period after reset must be all low
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'd128;
        rst0   = 1'b1;
        step();
        rst0 = 1'b0;
        clear_meas(0);
        wait_ps(0);
        chk("first_len", last_len[0], 510);
        chk("first_hi", last_hi[0], 0);
        wait_ps(0);
        chk("d50_len", last_len[0], 510);
        chk("d50_hi", last_hi[0], 256);
        wait_ps(0);
        chk("d50_hi2", last_hi[0], 256);

        // Duty 0: never high
        duty = 8'd0;
        wait_ps(0);
        for (int k = 0; k < 3; k++) begin
            wait_ps(0);
            chk("d0_hi", last_hi[0], 0);
        end

        // Duty full: never low
        duty = 8'hFF;
        wait_ps(0);
        wait_ps(0);
        chk("dff_hi", last_hi[0], 510);
        wait_ps(0);
        chk("dff_hi2", last_hi[0], 510);

        // Duty 1: one tick = two clocks high
        duty = 8'd1;
        wait_ps(0);
        wait_ps(0);
        chk("d1_hi", last_hi[0], 2);

        // Duty change mid-period only takes effect at the next period
        duty = 8'd64;
        wait_ps(0);
        repeat (200) step();
        duty = 8'd200;
        wait_ps(0);
        chk("glitch_old_hi", last_hi[0], 128);
        wait_ps(0);
        chk("glitch_new_hi", last_hi[0], 400);

        // Mixed modes
        en_out  = 16'hF0F0;
        en_pwm  = 16'hFF00;
        duty    = 8'd128;
        mon_bit = 15;
        wait_ps(0);
        wait_ps(0);
        chk("mix_hi15", last_hi[0], 256);
        repeat (10) step();
        chk("mix_high_phase", {16'd0, out0}, 32'h0000_F0F0);
        repeat (300) step();
        chk("mix_low_phase", {16'd0, out0}, 32'h0000_00F0);

        // CLK_DIV=1 instance: reset at pwm_cnt=150 with duty 200
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'd200;
        wait_ps(1);
        wait_ps(1);
        chk("div1_len", last_len[1], 255);
        chk("div1_hi", last_hi[1], 200);
        begin
            int got = 0;
            for (int k = 0; k < 600; k++) begin
                if (m_cnt[1] == 150) begin
                    got = 1;
                    break;
                end
                step();
            end
            if (got == 0) chk("cnt150_timeout", 32'd0, 32'd1);
        end
        chk("pre_rst_out1", {16'd0, out1}, 32'h0000_FFFF);
        rst1 = 1'b1;
        step();
        chk("rst_out1", {16'd0, out1}, 32'd0);
        rst1 = 1'b0;
        clear_meas(1);
        wait_ps(1);
        chk("post_rst_len", last_len[1], 255);
        chk("post_rst_hi", last_hi[1], 0);
        wait_ps(1);
        chk("post_rst_hi2", last_hi[1], 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five control registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip outputs.
- Each output is either off, static high, or PWM-modulated. All PWM channels share one counter and one duty cycle.
- The duty cycle is double-buffered and only takes effect at a period boundary, so waveforms never glitch mid-period.
- Sits directly downstream of the SPI register block; output bits go straight to uo_out/uio_out.

Parameters:
- CLK_DIV, 13, system clocks per PWM counter step. Legal range 1..255. 10 MHz / (13*255) ≈ 3.0 kHz PWM.
- PERIOD_MAX, 8'd254, last PWM counter value. Period is PERIOD_MAX+1 = 255 ticks.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- en_reg_out_7_0  input  8  output enable, bits 7:0
- en_reg_out_15_8  input  8  output enable, bits 15:8
- en_reg_pwm_7_0  input  8  PWM mode select, bits 7:0
- en_reg_pwm_15_8  input  8  PWM mode select, bits 15:8
- pwm_duty_cycle  input  8  requested duty; 0 = 0%, 8'hFF = 100%
- out  output  16  channel outputs
- period_start  output  1  one-cycle pulse when a new PWM period begins

Behaviour:
- Single clock domain. Reset is sampled on posedge clk only.
- Reset values:
  - out = 0, period_start = 0
  - div_cnt = 0, pwm_cnt = 0, duty_shadow = 0
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (div_cnt == CLK_DIV-1), combinational.
  - CLK_DIV = 1 gives tick every cycle.
- PWM counter:
  - 8-bit pwm_cnt advances only on tick.
  - On tick with pwm_cnt == PERIOD_MAX it wraps to 0; this is the "wrap" event.
- Duty shadow:
  - On a wrap, duty_shadow <= pwm_duty_cycle, sampled that same cycle.
  - Duty changes at any other time are invisible until the next wrap.
  - A change coincident with a wrap cycle is captured.
- period_start: registered. It is 1 in the cycle after a wrap (the first cycle with pwm_cnt == 0), otherwise 0.
- PWM level:
  - pwm_level = 1 if duty_shadow == 8'hFF.
  - Otherwise pwm_level = (pwm_cnt < duty_shadow).
  - High time is duty_shadow ticks of 255 (duty 128 → 128/255 high).
- Output mux, per bit i (en_out = {15_8, 7_0}, en_pwm likewise):
  - en_out[i] = 0 → out[i] = 0, regardless of en_pwm[i].
  - en_out[i] = 1, en_pwm[i] = 0 → out[i] = 1.
  - en_out[i] = 1, en_pwm[i] = 1 → out[i] = pwm_level.
  - out is registered: enable changes appear exactly 1 clk later, and PWM edges lag pwm_cnt by 1 clk.
- Reset mid-period:
  - All counters and the shadow clear next edge; out goes to 0 one cycle after rst is sampled.
  - After rst release, duty_shadow stays 0 until the first wrap, so PWM channels are low for the first full period (255*CLK_DIV clks).
- Enable registers are used live (not shadowed); only duty is double-buffered.
- No combinational path from any input to out.

Decomposition:
- Shared package pwm_pkg holds:
  - PWM_PERIOD_MAX = 8'd254
  - DUTY_FULL = 8'hFF
  - DEFAULT_CLK_DIV = 13
  - the enum for channel mode {OFF, STATIC_HIGH, PWM}
- One natural sub-module: pwm_timebase (prescaler + pwm_cnt + wrap/period_start + duty_shadow), emitting pwm_level and period_start.
- The top level holds the 16-bit registered output mux.

Test Plan:
Bench uses CLK_DIV = 2 unless stated.
- Reset/static: rst for 3 clks, then en_out = 16'h00FF, en_pwm = 0 → out == 0 during reset; out == 16'h00FF one clk after the enables settle; period_start pulses every 510 clks.
- Duty 50%: en_out = en_pwm = 16'hFFFF, duty = 128, wait past the first wrap → each period out == 16'hFFFF for 256 clks and 16'h0000 for 254 clks; first period after reset is all low.
- Extremes: duty = 0 → out stays 0 for 3 periods. duty = 8'hFF → out stays 16'hFFFF with no low cycle. duty = 1 → high for exactly 2 clks per period.
- Glitch-free update: duty = 64, change to 200 mid-period (pwm_cnt = 100) → current period completes with 64-tick high time; new 200-tick high time starts at the next period_start.
- Mixed modes: en_out = 16'hF0F0, en_pwm = 16'hFF00, duty = 128 → bits 15:12 PWM, bits 7:4 constant 1, bits 11:8 (PWM without output enable) and all other bits constant 0.
- Reset mid-operation and CLK_DIV = 1 build: assert rst at pwm_cnt = 150 with duty = 200 → out = 0 next cycle; after release, period is 255 clks and the first high pulse appears only after the first period_start.
